// File: rtl/pcache_if.sv
// Pipeline-side and memory-side signal bundle for pcache.
// The cache takes the slave view. A pipeline stage paired with a memory controller (or a bench) takes the master view.
interface pcache_if #(
  parameter int ADDR_W     = 32,
  parameter int DATA_BYTES = 8,
  parameter int MEM_BYTES  = 8
);
  localparam int SZ_W = $clog2(DATA_BYTES) + 1;

  logic                    REQ;
  logic                    WE;
  logic [ADDR_W-1:0]       PADDR;
  logic [SZ_W-1:0]         SIZE;
  logic [DATA_BYTES*8-1:0] DIN;
  logic                    FLUSH;
  logic                    R;
  logic                    VALID;
  logic [DATA_BYTES*8-1:0] DOUT;
  logic                    ERR;
  logic [15:0]             HIT_CNT;
  logic [15:0]             MISS_CNT;
  logic                    M_REQ;
  logic                    M_WE;
  logic [ADDR_W-1:0]       M_ADDR;
  logic [SZ_W-1:0]         M_SIZE;
  logic [DATA_BYTES*8-1:0] M_DIN;
  logic                    M_ACK;
  logic [MEM_BYTES*8-1:0]  M_DOUT;

  modport slave (
    input  REQ, WE, PADDR, SIZE, DIN, FLUSH, M_ACK, M_DOUT,
    output R, VALID, DOUT, ERR, HIT_CNT, MISS_CNT,
           M_REQ, M_WE, M_ADDR, M_SIZE, M_DIN
  );

  modport master (
    output REQ, WE, PADDR, SIZE, DIN, FLUSH, M_ACK, M_DOUT,
    input  R, VALID, DOUT, ERR, HIT_CNT, MISS_CNT,
           M_REQ, M_WE, M_ADDR, M_SIZE, M_DIN
  );
endinterface

// File: rtl/pcache.sv
// Direct-mapped PIPT cache with multi-beat line fill, write-through without allocate,
// single-cycle flush-all and saturating hit/miss counters.
module pcache #(
  parameter int ADDR_W     = 32,
  parameter int LINE_BYTES = 16,
  parameter int NUM_LINES  = 32,
  parameter int DATA_BYTES = 8,
  parameter int MEM_BYTES  = 8
) (
  input logic      CLK,
  input logic      RST,
  pcache_if.slave  bus
);
  localparam int OFF    = $clog2(LINE_BYTES);
  localparam int IDX    = $clog2(NUM_LINES);
  localparam int TAG_W  = ADDR_W - OFF - IDX;
  localparam int SZ_W   = $clog2(DATA_BYTES) + 1;
  localparam int LINE_W = LINE_BYTES * 8;
  localparam int DW     = DATA_BYTES * 8;
  localparam int MW     = MEM_BYTES * 8;
  localparam int BEATS  = LINE_BYTES / MEM_BYTES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [2:0] {IDLE, LOOKUP, FILL, WMEM, RESP} state_t;

  state_t              state_reg, state_next;
  logic                we_reg;
  logic [ADDR_W-1:0]   paddr_reg;
  logic [SZ_W-1:0]     size_reg;
  logic [DW-1:0]       din_reg;
  logic [NUM_LINES-1:0] valid_reg;
  logic [TAG_W-1:0]    tag_reg [NUM_LINES];
  logic [LINE_W-1:0]   data_reg [NUM_LINES];
  logic [BEAT_W-1:0]   beat_reg;
  logic                replay_reg;
  logic                err_reg;
  logic [DW-1:0]       dout_reg;
  logic [15:0]         hit_cnt_reg;
  logic [15:0]         miss_cnt_reg;
  logic                flush_busy_reg;

  // Address decode of the latched request
  logic [IDX-1:0]    idx;
  logic [TAG_W-1:0]  tag;
  logic [OFF-1:0]    off;
  logic              hit;
  logic              size_pow2;
  logic              legal;
  logic              last_beat;
  logic [LINE_W-1:0] line_rd;
  logic [LINE_W-1:0] rd_shift;
  logic [LINE_W-1:0] din_shift;
  logic [DW-1:0]     rd_data;
  logic [LINE_W-1:0] wr_line;
  logic [LINE_W-1:0] fill_line;
  logic [OFF-1:0]    beat_off;
  logic [ADDR_W-1:0] fill_addr;

  assign idx       = paddr_reg[OFF+IDX-1:OFF];
  assign tag       = paddr_reg[ADDR_W-1:OFF+IDX];
  assign off       = paddr_reg[OFF-1:0];
  assign line_rd   = data_reg[idx];
  assign hit       = valid_reg[idx] && (tag_reg[idx] == tag);
  assign size_pow2 = (size_reg != '0) && ((size_reg & (size_reg - 1'b1)) == '0);
  assign legal     = size_pow2 && (int'(size_reg) <= DATA_BYTES)
                     && (int'(off) + int'(size_reg) <= LINE_BYTES);
  assign last_beat = (beat_reg == BEAT_W'(BEATS - 1));
  assign rd_shift  = line_rd >> {off, 3'b000};
  assign din_shift = LINE_W'(din_reg) << {off, 3'b000};
  assign beat_off  = OFF'(int'(beat_reg) * MEM_BYTES);
  assign fill_addr = {paddr_reg[ADDR_W-1:OFF], beat_off};

  genvar gi;
  generate
    for (gi = 0; gi < DATA_BYTES; gi++) begin : g_rd
      assign rd_data[gi*8 +: 8] = (int'(size_reg) > gi) ? rd_shift[gi*8 +: 8] : 8'h00;
    end
    for (gi = 0; gi < LINE_BYTES; gi++) begin : g_wr
      assign wr_line[gi*8 +: 8] =
        ((int'(off) <= gi) && (gi < int'(off) + int'(size_reg))) ? din_shift[gi*8 +: 8]
                                                                  : line_rd[gi*8 +: 8];
    end
    for (gi = 0; gi < BEATS; gi++) begin : g_fill
      assign fill_line[gi*MW +: MW] = (beat_reg == BEAT_W'(gi)) ? bus.M_DOUT
                                                                : line_rd[gi*MW +: MW];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (!flush_busy_reg && !bus.FLUSH && bus.REQ) state_next = LOOKUP;
      LOOKUP: begin
        if (!legal)       state_next = RESP;
        else if (we_reg)  state_next = WMEM;
        else if (hit)     state_next = RESP;
        else              state_next = FILL;
      end
      FILL:   if (bus.M_ACK && last_beat) state_next = LOOKUP;
      WMEM:   if (bus.M_ACK) state_next = RESP;
      RESP:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg      <= IDLE;
      we_reg         <= 1'b0;
      paddr_reg      <= '0;
      size_reg       <= '0;
      din_reg        <= '0;
      valid_reg      <= '0;
      beat_reg       <= '0;
      replay_reg     <= 1'b0;
      err_reg        <= 1'b0;
      dout_reg       <= '0;
      hit_cnt_reg    <= '0;
      miss_cnt_reg   <= '0;
      flush_busy_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      flush_busy_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (!flush_busy_reg) begin
            if (bus.FLUSH) begin
              valid_reg      <= '0;
              flush_busy_reg <= 1'b1;
            end else if (bus.REQ) begin
              we_reg     <= bus.WE;
              paddr_reg  <= bus.PADDR;
              size_reg   <= bus.SIZE;
              din_reg    <= bus.DIN;
              replay_reg <= 1'b0;
            end
          end
        end
        LOOKUP: begin
          replay_reg <= 1'b0;
          if (!legal) begin
            err_reg  <= 1'b1;
            dout_reg <= '0;
          end else begin
            err_reg <= 1'b0;
            if (hit) begin
              if (!we_reg) dout_reg <= rd_data;
              if (!replay_reg && hit_cnt_reg != 16'hFFFF) hit_cnt_reg <= hit_cnt_reg + 1'b1;
            end else begin
              if (miss_cnt_reg != 16'hFFFF) miss_cnt_reg <= miss_cnt_reg + 1'b1;
              if (!we_reg) begin
                // Old contents get overwritten beat by beat, so the line must not look valid meanwhile
                valid_reg[idx] <= 1'b0;
                beat_reg       <= '0;
              end
            end
          end
        end
        FILL: begin
          if (bus.M_ACK) begin
            beat_reg <= beat_reg + 1'b1;
            if (last_beat) begin
              valid_reg[idx] <= 1'b1;
              replay_reg     <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Line data and tags need no reset: the valid vector guards them
  always_ff @(posedge CLK) begin
    if (state_reg == LOOKUP && legal && we_reg && hit) begin
      data_reg[idx] <= wr_line;
    end
    if (state_reg == FILL && bus.M_ACK) begin
      data_reg[idx] <= fill_line;
      if (last_beat) tag_reg[idx] <= tag;
    end
  end

  assign bus.R        = (state_reg == IDLE) && !flush_busy_reg;
  assign bus.VALID    = (state_reg == RESP);
  assign bus.ERR      = (state_reg == RESP) && err_reg;
  assign bus.DOUT     = dout_reg;
  assign bus.HIT_CNT  = hit_cnt_reg;
  assign bus.MISS_CNT = miss_cnt_reg;
  assign bus.M_REQ    = (state_reg == FILL) || (state_reg == WMEM);
  assign bus.M_WE     = (state_reg == WMEM);
  assign bus.M_ADDR   = (state_reg == FILL) ? fill_addr :
                        (state_reg == WMEM) ? paddr_reg : '0;
  assign bus.M_SIZE   = (state_reg == FILL) ? SZ_W'(MEM_BYTES) :
                        (state_reg == WMEM) ? size_reg : '0;
  assign bus.M_DIN    = (state_reg == WMEM) ? din_reg : '0;
endmodule
